// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the 64-bit byte-addressed data-memory port.
// The memory always reads and writes 8 bytes at the address, so sub-doubleword
// stores are done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; latches it and range-checks on accept
// READ  | mem_r high; load data or store merge base is sampled at the end
// WRITE | mem_w high; merged (or full doubleword) data driven to memory
// RESP  | response valid; held until rsp_ready
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] mem_adr,
    output logic [63:0] mem_datain,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [63:0] mem_dataout
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rbuf_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic [64:0] end_addr;
    logic        req_bad;

    // End address in 65 bits so a huge address cannot wrap into range.
    assign end_addr = {1'b0, req_addr} + 65'd8;
    assign req_bad  = (end_addr > 65'(MEM_BYTES)) || (req_we && req_funct3[2]);

    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] d);
        case (f3[1:0])
            2'b00:   extend = f3[2] ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'b01:   extend = f3[2] ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'b10:   extend = f3[2] ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [1:0] sz, input logic [63:0] old,
                                          input logic [63:0] nw);
        case (sz)
            2'b00:   merge = {old[63:8],  nw[7:0]};
            2'b01:   merge = {old[63:16], nw[15:0]};
            2'b10:   merge = {old[63:32], nw[31:0]};
            default: merge = nw;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, read sample and response data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 64'b0;
            wdata_q <= 64'b0;
            rbuf_q  <= 64'b0;
            rdata_q <= 64'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_bad;
                        rdata_q <= 64'b0;
                    end
                end
                READ: begin
                    if (we_q) begin
                        rbuf_q <= mem_dataout;
                    end else begin
                        rdata_q <= extend(f3_q, mem_dataout);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and decoded outputs; memory outputs are zero outside their states.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        mem_adr    = 64'b0;
        mem_datain = 64'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_nx = RESP;
                    end else if (req_we && req_funct3[1:0] == 2'b11) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            READ: begin
                mem_r    = 1'b1;
                mem_adr  = addr_q;
                state_nx = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_w      = 1'b1;
                mem_adr    = addr_q;
                mem_datain = merge(f3_q[1:0], rbuf_q, wdata_q);
                state_nx   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the 64-bit byte-addressed data-memory port. It accepts load and store requests from the CPU execute stage through a valid/ready handshake and drives the memory's address, write-data, write-strobe and read-strobe. It samples the memory's combinational read data. Loads are sign- or zero-extended. Byte, half and word stores are done as read-modify-write, because the memory always writes 8 bytes starting at the address.

Parameters:
MEM_BYTES, 256, size of the data memory in bytes; used for the range check.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV64 width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  in  64  byte address
req_wdata  in  64  store data; the low 8/16/32/64 bits are used
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  64  extended load data; 0 for stores and for errors
rsp_err  out  1  request rejected; no memory access occurred
mem_adr  out  64  memory address
mem_datain  out  64  memory write data
mem_w  out  1  memory write strobe; memory writes on posedge clk
mem_r  out  1  memory read enable
mem_dataout  in  64  memory read data; combinational, high-Z when mem_r = 0

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset drives state to IDLE immediately and asynchronously.
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_adr=0, mem_datain=0, mem_w=0, mem_r=0.
- Memory outputs are decoded from state and are zero outside their states:
  - mem_r=1 only in READ.
  - mem_w=1 only in WRITE.
  - mem_adr = latched address in READ and WRITE, else 0.
  - mem_datain = merged data in WRITE, else 0.
- IDLE: req_ready=1. On req_valid at posedge, latch we, funct3, addr and wdata. Size N = 1/2/4/8 from funct3[1:0].
- Error check on accept:
  - Error if addr + 8 > MEM_BYTES. The memory always touches 8 bytes, so every access must fit. The sum is computed in 65 bits, so there is no wrap-around.
  - Error if the request is a store with funct3[2] = 1.
  - On error: go to RESP with rsp_err=1 and rsp_rdata=0. mem_r and mem_w never assert.
- Loads: IDLE -> READ -> RESP.
  - At the posedge ending READ, capture mem_dataout into rsp_rdata.
  - Keep the low N bytes. Sign-extend for funct3[2]=0 and zero-extend for funct3[2]=1; LD passes all 64 bits.
- Store D: IDLE -> WRITE -> RESP. mem_datain = wdata.
- Store B/H/W: IDLE -> READ -> WRITE -> RESP.
  - The READ sample is held in a register.
  - WRITE drives that register with its low N bytes replaced by the low N bytes of wdata. The upper 8-N bytes are rewritten unchanged.
- Latency, counted in cycles after the accept edge: load and SD responses are valid 2 cycles later, sub-doubleword stores 3 cycles later, errors 1 cycle later.
- RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_ready is sampled high, then the FSM returns to IDLE.
  - Store responses give rsp_rdata=0 and rsp_err=0.
  - req_ready=0 in every non-IDLE state; a new request is accepted no earlier than the cycle after the response handshake.
- Reset mid-operation: when rst asserts during WRITE, mem_w drops combinationally, so no memory write occurs at the following edge. A pending response is discarded.

Test Plan:
- Memory preloaded MEM[i]=i; LD addr 0x10 -> mem_r high for one cycle at adr 0x10; rsp_rdata=0x1716151413121110 two cycles after accept; rsp_err=0.
- LB addr 0x80 -> rsp_rdata=0xFFFFFFFFFFFFFF80; LBU addr 0x80 -> 0x0000000000000080; LH addr 0x90 -> 0xFFFFFFFFFFFF9190; LWU addr 0x90 -> 0x0000000093929190.
- SB addr 0x20, wdata 0x55AB -> READ then WRITE with mem_datain=0x27262524232221AB; following LD 0x20 returns 0x27262524232221AB; SD 0x40 with 0x0123456789ABCDEF, then LD 0x40 returns the same value.
- LD addr 0xF9, and SW with funct3 110 at addr 0 -> rsp_valid one cycle after accept with rsp_err=1, rsp_rdata=0; mem_r and mem_w stay 0.
- Backpressure: hold rsp_ready=0 for 5 cycles after LD 0x10 -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; raise rsp_ready -> IDLE next cycle, req_ready=1.
- Assert rst during the WRITE cycle of SD 0x30 with 0xFFFFFFFFFFFFFFFF -> mem_w falls immediately; after reset, LD 0x30 returns 0x3736353433323130.
